// File: rtl/deserialize_input.sv
// Purpose: receive side of the single-wire LSB-first word link; assembles WIDTH-bit words.
// Latency: data_valid rises 1 clk after the last serial bit is sampled.
// Backpressure: one-word holding register; a word completing while it is full and not
//               being consumed is dropped and flagged on the sticky overrun bit.
module deserialize_input #(
    parameter int WIDTH     = 32,
    parameter int START_LAG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             start,
    input  logic             data_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int            BW       = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    // Two lag cycles are absorbed by the S_IDLE -> S_WAIT and S_WAIT -> S_SHIFT hops.
    localparam logic [3:0]    LAG_INIT = (START_LAG >= 2) ? 4'(START_LAG - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    // Only WIDTH-1 bits are stored: the final bit goes straight from serial_in into the word.
    logic [WIDTH-1:1] sr;
    logic [WIDTH-1:1] sr_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [3:0]       lag_cnt;
    logic [3:0]       lag_cnt_nxt;
    logic             word_done;
    logic [WIDTH-1:0] shifted;

    assign shifted = {serial_in, sr};
    assign busy    = (state != S_IDLE);

    // State and shift datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            lag_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            bit_cnt <= bit_cnt_nxt;
            lag_cnt <= lag_cnt_nxt;
        end
    end

    // Next-state logic: start lag handling, bit shifting and word completion.
    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        bit_cnt_nxt = bit_cnt;
        lag_cnt_nxt = lag_cnt;
        word_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (START_LAG == 0) begin
                        // Bit 0 is on the wire together with the strobe.
                        sr_nxt      = shifted[WIDTH-1:1];
                        bit_cnt_nxt = BW'(1);
                        state_nxt   = S_SHIFT;
                    end else if (START_LAG == 1) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = S_SHIFT;
                    end else begin
                        lag_cnt_nxt = LAG_INIT;
                        state_nxt   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (lag_cnt != 4'd0) begin
                    lag_cnt_nxt = lag_cnt - 4'd1;
                end else begin
                    bit_cnt_nxt = '0;
                    state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_nxt      = shifted[WIDTH-1:1];
                bit_cnt_nxt = bit_cnt + BW'(1);
                if (bit_cnt == LAST_BIT) begin
                    word_done   = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Holding register: load on completion when empty or drained this cycle, else drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (word_done) begin
            if (!data_valid || data_ready) begin
                data_out   <= shifted;
                data_valid <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

    // Sticky overrun: a dropped word sets it, and setting beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (word_done && data_valid && !data_ready) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserialize_input.sv
module tb_deserialize_input;

    logic clk = 1'b0;
    logic reset;

    // Instance 0: WIDTH=32, START_LAG=1
    logic        serial_in0, start0, data_ready0, clr_err0;
    logic [31:0] data_out0;
    logic        data_valid0, busy0, overrun0;
    // Instance 1: WIDTH=8, START_LAG=0
    logic        serial_in1, start1, data_ready1, clr_err1;
    logic [7:0]  data_out1;
    logic        data_valid1, busy1, overrun1;
    // Instance 2: WIDTH=8, START_LAG=3
    logic        serial_in2, start2, data_ready2, clr_err2;
    logic [7:0]  data_out2;
    logic        data_valid2, busy2, overrun2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    deserialize_input #(.WIDTH(32), .START_LAG(1)) dut0 (
        .clk(clk), .reset(reset), .serial_in(serial_in0), .start(start0),
        .data_ready(data_ready0), .clr_err(clr_err0), .data_out(data_out0),
        .data_valid(data_valid0), .busy(busy0), .overrun(overrun0)
    );

    deserialize_input #(.WIDTH(8), .START_LAG(0)) dut1 (
        .clk(clk), .reset(reset), .serial_in(serial_in1), .start(start1),
        .data_ready(data_ready1), .clr_err(clr_err1), .data_out(data_out1),
        .data_valid(data_valid1), .busy(busy1), .overrun(overrun1)
    );

    deserialize_input #(.WIDTH(8), .START_LAG(3)) dut2 (
        .clk(clk), .reset(reset), .serial_in(serial_in2), .start(start2),
        .data_ready(data_ready2), .clr_err(clr_err2), .data_out(data_out2),
        .data_valid(data_valid2), .busy(busy2), .overrun(overrun2)
    );

    // Advance one clock; outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one 32-bit frame on instance 0 starting now (cycle t). Returns with the
    // bench sitting in cycle t+33. extra_start selects a bit index at which a stray
    // start pulse is driven (-1 for none).
    task automatic frame32(input logic [31:0] w, input int extra_start,
                           input logic rdy_last, input logic rdy_after,
                           output logic busy_ok, output logic pre_valid);
        busy_ok    = 1'b1;
        pre_valid  = 1'b0;
        start0     = 1'b1;
        serial_in0 = 1'b0;
        step();
        for (int k = 0; k < 32; k++) begin
            serial_in0 = w[k];
            start0     = (k == extra_start);
            if (k == 31) begin
                data_ready0 = rdy_last;
                pre_valid   = data_valid0;
            end
            if (busy0 !== 1'b1) busy_ok = 1'b0;
            step();
        end
        start0      = 1'b0;
        serial_in0  = 1'b0;
        data_ready0 = rdy_after;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        checks++;
        if ({data_valid0, busy0, overrun0} !== 3'b000)
            $display("FAIL reset_flags0: got %b expected 000", {data_valid0, busy0, overrun0});
        checks++;
        if (data_out0 !== 32'h0)
            $display("FAIL reset_data0: got %h expected 00000000", data_out0);
        checks++;
        if ({data_valid1, busy1, data_valid2, busy2} !== 4'b0000)
            $display("FAIL reset_flags12: got %b expected 0000",
                     {data_valid1, busy1, data_valid2, busy2});
        failures += ({data_valid0, busy0, overrun0} !== 3'b000) ? 1 : 0;
        failures += (data_out0 !== 32'h0) ? 1 : 0;
        failures += ({data_valid1, busy1, data_valid2, busy2} !== 4'b0000) ? 1 : 0;
    endtask

    task automatic test_single();
        logic busy_ok, pre_valid;
        data_ready0 = 1'b1;
        frame32(32'h3F800000, -1, 1'b1, 1'b1, busy_ok, pre_valid);
        checks++;
        if (busy_ok !== 1'b1) begin
            failures++; $display("FAIL single_busy: busy dropped during t+1..t+32, expected 1");
        end
        checks++;
        if (pre_valid !== 1'b0) begin
            failures++; $display("FAIL single_early_valid: got %b at t+32 expected 0", pre_valid);
        end
        checks++;
        if (data_valid0 !== 1'b1 || busy0 !== 1'b0) begin
            failures++; $display("FAIL single_valid: valid=%b busy=%b expected 1 0", data_valid0, busy0);
        end
        checks++;
        if (data_out0 !== 32'h3F800000) begin
            failures++; $display("FAIL single_data: got %h expected 3f800000", data_out0);
        end
        step();
        checks++;
        if (data_valid0 !== 1'b0) begin
            failures++; $display("FAIL single_consume: valid=%b expected 0", data_valid0);
        end
    endtask

    task automatic test_ignored_start();
        logic busy_ok, pre_valid;
        data_ready0 = 1'b1;
        frame32(32'h3F800000, 9, 1'b1, 1'b1, busy_ok, pre_valid);
        checks++;
        if (busy_ok !== 1'b1 || pre_valid !== 1'b0) begin
            failures++; $display("FAIL ign_busy: busy_ok=%b pre_valid=%b expected 1 0", busy_ok, pre_valid);
        end
        checks++;
        if (data_valid0 !== 1'b1 || data_out0 !== 32'h3F800000 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL ign_result: valid=%b data=%h busy=%b expected 1 3f800000 0",
                     data_valid0, data_out0, busy0);
        end
        step();
        checks++;
        if (data_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++; $display("FAIL ign_after: valid=%b busy=%b expected 0 0", data_valid0, busy0);
        end
    endtask

    task automatic test_overrun();
        logic busy_ok, pre_valid;
        data_ready0 = 1'b0;
        frame32(32'hA5A5A5A5, -1, 1'b0, 1'b0, busy_ok, pre_valid);
        checks++;
        if (data_valid0 !== 1'b1 || data_out0 !== 32'hA5A5A5A5 || overrun0 !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first: valid=%b data=%h ovr=%b expected 1 a5a5a5a5 0",
                     data_valid0, data_out0, overrun0);
        end
        frame32(32'h12345678, -1, 1'b0, 1'b0, busy_ok, pre_valid);
        checks++;
        if (data_out0 !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL ovr_data_held: got %h expected a5a5a5a5", data_out0);
        end
        checks++;
        if (overrun0 !== 1'b1 || data_valid0 !== 1'b1) begin
            failures++; $display("FAIL ovr_flag: ovr=%b valid=%b expected 1 1", overrun0, data_valid0);
        end
        clr_err0 = 1'b1;
        step();
        clr_err0 = 1'b0;
        checks++;
        if (overrun0 !== 1'b0 || data_valid0 !== 1'b1 || data_out0 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL ovr_clear: ovr=%b valid=%b data=%h expected 0 1 a5a5a5a5",
                     overrun0, data_valid0, data_out0);
        end
    endtask

    task automatic test_back_to_back();
        logic busy_ok, pre_valid;
        data_ready0 = 1'b1;
        step();
        data_ready0 = 1'b0;
        checks++;
        if (data_valid0 !== 1'b0) begin
            failures++; $display("FAIL b2b_drain: valid=%b expected 0", data_valid0);
        end
        frame32(32'hA5A5A5A5, -1, 1'b0, 1'b0, busy_ok, pre_valid);
        frame32(32'h12345678, -1, 1'b1, 1'b0, busy_ok, pre_valid);
        checks++;
        if (data_out0 !== 32'h12345678 || data_valid0 !== 1'b1 || overrun0 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: data=%h valid=%b ovr=%b expected 12345678 1 0",
                     data_out0, data_valid0, overrun0);
        end
        step();
        checks++;
        if (data_out0 !== 32'h12345678 || data_valid0 !== 1'b1) begin
            failures++; $display("FAIL b2b_hold: data=%h valid=%b expected 12345678 1",
                                 data_out0, data_valid0);
        end
    endtask

    task automatic test_midframe_reset();
        logic busy_ok, pre_valid;
        logic [31:0] w;
        w = 32'hCAFEF00D;
        data_ready0 = 1'b0;
        start0      = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            serial_in0 = w[k];
            step();
        end
        serial_in0 = w[16];
        reset      = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (busy0 !== 1'b0 || data_valid0 !== 1'b0 || data_out0 !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b valid=%b data=%h expected 0 0 00000000",
                     busy0, data_valid0, data_out0);
        end
        serial_in0 = 1'b1;
        step();
        step();
        checks++;
        if (busy0 !== 1'b0 || data_valid0 !== 1'b0) begin
            failures++; $display("FAIL mid_idle: busy=%b valid=%b expected 0 0", busy0, data_valid0);
        end
        frame32(32'hDEADBEEF, -1, 1'b1, 1'b1, busy_ok, pre_valid);
        checks++;
        if (data_valid0 !== 1'b1 || data_out0 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mid_next: valid=%b data=%h expected 1 deadbeef",
                                 data_valid0, data_out0);
        end
    endtask

    task automatic test_lag0();
        logic [7:0] w;
        w = 8'h81;
        data_ready1 = 1'b1;
        start1      = 1'b1;
        serial_in1  = w[0];
        checks++;
        if (busy1 !== 1'b0) begin
            failures++; $display("FAIL lag0_busy_t: got %b expected 0", busy1);
        end
        step();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            failures++; $display("FAIL lag0_busy_t1: got %b expected 1", busy1);
        end
        for (int k = 1; k < 8; k++) begin
            serial_in1 = w[k];
            if (k == 7) begin
                checks++;
                if (data_valid1 !== 1'b0) begin
                    failures++; $display("FAIL lag0_early: valid=%b at t+7 expected 0", data_valid1);
                end
            end
            step();
        end
        serial_in1 = 1'b0;
        checks++;
        if (data_valid1 !== 1'b1 || data_out1 !== 8'h81) begin
            failures++; $display("FAIL lag0_result: valid=%b data=%h expected 1 81", data_valid1, data_out1);
        end
    endtask

    task automatic test_lag3();
        logic [7:0] w;
        w = 8'h5C;
        data_ready2 = 1'b1;
        start2      = 1'b1;
        serial_in2  = 1'b1;
        step();
        start2 = 1'b0;
        checks++;
        if (busy2 !== 1'b1) begin
            failures++; $display("FAIL lag3_busy: got %b expected 1", busy2);
        end
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            serial_in2 = w[k];
            if (k == 7) begin
                checks++;
                if (data_valid2 !== 1'b0) begin
                    failures++; $display("FAIL lag3_early: valid=%b at t+10 expected 0", data_valid2);
                end
            end
            step();
        end
        serial_in2 = 1'b0;
        checks++;
        if (data_valid2 !== 1'b1 || data_out2 !== 8'h5C) begin
            failures++; $display("FAIL lag3_result: valid=%b data=%h expected 1 5c", data_valid2, data_out2);
        end
    endtask

    initial begin
        reset = 1'b0;
        serial_in0 = 1'b0; start0 = 1'b0; data_ready0 = 1'b0; clr_err0 = 1'b0;
        serial_in1 = 1'b0; start1 = 1'b0; data_ready1 = 1'b0; clr_err1 = 1'b0;
        serial_in2 = 1'b0; start2 = 1'b0; data_ready2 = 1'b0; clr_err2 = 1'b0;
        #2;
        test_reset();
        test_single();
        test_ignored_start();
        test_overrun();
        test_back_to_back();
        test_midframe_reset();
        test_lag0();
        test_lag3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
